calc_entry_ctrl: RTL and testbench

Keypad-driven two-operand decimal calculator controller. Consumes one-cycle key strobes from the keypad scanner and sequences operand entry, operator selection and a digit-serial BCD add/subtract. Drives the 6-digit packed-BCD display word for the seven-segment driver. Sits between the keypad scanner and the display mux, and replaces direct digit shifting in the display path.

---
 rtl/calc_entry_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_ctrl.sv
// Keypad calculator controller: two-operand BCD entry,
// digit-serial add/subtract, packed-BCD display word.
module calc_entry_ctrl #(
    parameter int NDIG = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        press,
    input  logic [3:0]  scan_code,
    output logic [23:0] disp_code,
    output logic        neg,
    output logic        busy,
    output logic        done,
    output logic [1:0]  phase
);

    localparam int AW = 4 * NDIG;
    localparam int RW = 4 * (NDIG + 1);
    localparam int CW = $clog2(NDIG + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_CALC = 2'd2,
        S_RES  = 2'd3
    } state_t;

    state_t        r_state, w_state;
    logic [AW-1:0] r_a, w_a, r_b, w_b;
    logic [AW-1:0] r_x, w_x, r_y, w_y;
    logic [CW-1:0] r_cnt_a, w_cnt_a, r_cnt_b, w_cnt_b;
    logic [RW-1:0] r_r, w_r;
    logic [IW-1:0] r_idx, w_idx;
    logic          r_op, w_op;
    logic          r_c, w_c;
    logic          r_neg, w_neg;
    logic [23:0]   r_disp, w_disp;
    logic          r_neg_o, w_neg_o;
    logic          r_busy, w_busy;
    logic          r_done, w_done;

    logic w_dig, w_add, w_sub, w_eq, w_clr, w_bksp;
    assign w_dig  = press && (scan_code <= 4'd9);
    assign w_add  = press && (scan_code == 4'hA);
    assign w_sub  = press && (scan_code == 4'hB);
    assign w_clr  = press && (scan_code == 4'hC);
    assign w_eq   = press && (scan_code == 4'hE);
    assign w_bksp = press && (scan_code == 4'hF);

    // The operand being edited depends on which entry state we are in
    logic [AW-1:0] w_opd, w_opd_n;
    logic [CW-1:0] w_cnt, w_cnt_n;
    assign w_opd = (r_state == S_A) ? r_a : r_b;
    assign w_cnt = (r_state == S_A) ? r_cnt_a : r_cnt_b;

    logic [3:0] w_xd, w_yd, w_dg;
    logic [4:0] w_s;
    assign w_xd = r_x[r_idx*4 +: 4];
    assign w_yd = r_y[r_idx*4 +: 4];

    always_comb begin
        w_state = r_state;
        w_a     = r_a;
        w_b     = r_b;
        w_x     = r_x;
        w_y     = r_y;
        w_cnt_a = r_cnt_a;
        w_cnt_b = r_cnt_b;
        w_r     = r_r;
        w_idx   = r_idx;
        w_op    = r_op;
        w_c     = r_c;
        w_neg   = r_neg;
        w_done  = 1'b0;
        w_opd_n = w_opd;
        w_cnt_n = w_cnt;
        w_s     = '0;
        w_dg    = '0;

        unique case (r_state)
            S_A, S_B: begin
                if (w_dig && (w_cnt < CW'(NDIG))) begin
                    w_opd_n = (w_opd << 4) | AW'(scan_code);
                    w_cnt_n = w_cnt + CW'(1);
                end else if (w_bksp && (w_cnt != '0)) begin
                    w_opd_n = w_opd >> 4;
                    w_cnt_n = w_cnt - CW'(1);
                end
                if (r_state == S_A) begin
                    w_a     = w_opd_n;
                    w_cnt_a = w_cnt_n;
                    if (w_add || w_sub) begin
                        w_op    = w_sub;
                        w_b     = '0;
                        w_cnt_b = '0;
                        w_state = S_B;
                    end
                end else begin
                    w_b     = w_opd_n;
                    w_cnt_b = w_cnt_n;
                    if ((w_add || w_sub) && (r_cnt_b == '0))
                        w_op = w_sub;
                    if (w_eq && (r_cnt_b != '0)) begin
                        // Subtract always runs larger minus smaller
                        if (r_op && (r_a < r_b)) begin
                            w_x   = r_b;
                            w_y   = r_a;
                            w_neg = 1'b1;
                        end else begin
                            w_x   = r_a;
                            w_y   = r_b;
                            w_neg = 1'b0;
                        end
                        w_idx   = '0;
                        w_c     = 1'b0;
                        w_r     = '0;
                        w_state = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!r_op) begin
                    w_s = {1'b0, w_xd} + {1'b0, w_yd} + {4'b0, r_c};
                    w_c = (w_s > 5'd9);
                    w_dg = w_c ? (w_s[3:0] + 4'd6) : w_s[3:0];
                end else begin
                    w_s = {1'b0, w_xd} - {1'b0, w_yd} - {4'b0, r_c};
                    w_c = w_s[4];
                    w_dg = w_c ? (w_s[3:0] + 4'd10) : w_s[3:0];
                end
                w_r[r_idx*4 +: 4] = w_dg;
                if (r_idx == IW'(NDIG - 1)) begin
                    w_r[RW-1 -: 4] = r_op ? 4'd0 : {3'b0, w_c};
                    w_state = S_RES;
                    w_done  = 1'b1;
                end else begin
                    w_idx = r_idx + IW'(1);
                end
            end
            S_RES: begin
                if (w_dig) begin
                    w_a     = AW'(scan_code);
                    w_cnt_a = CW'(1);
                    w_b     = '0;
                    w_cnt_b = '0;
                    w_neg   = 1'b0;
                    w_state = S_A;
                end
            end
        endcase

        if (w_clr) begin
            w_state = S_A;
            w_a     = '0;
            w_b     = '0;
            w_x     = '0;
            w_y     = '0;
            w_cnt_a = '0;
            w_cnt_b = '0;
            w_r     = '0;
            w_idx   = '0;
            w_op    = 1'b0;
            w_c     = 1'b0;
            w_neg   = 1'b0;
            w_done  = 1'b0;
        end

        unique case (w_state)
            S_A:         w_disp = 24'(w_a);
            S_B, S_CALC: w_disp = 24'(w_b);
            S_RES:       w_disp = 24'(w_r);
        endcase
        w_neg_o = (w_state == S_RES) && w_neg;
        w_busy  = (w_state == S_CALC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_r     <= '0;
            r_idx   <= '0;
            r_op    <= 1'b0;
            r_c     <= 1'b0;
            r_neg   <= 1'b0;
            r_disp  <= '0;
            r_neg_o <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_a     <= w_a;
            r_b     <= w_b;
            r_x     <= w_x;
            r_y     <= w_y;
            r_cnt_a <= w_cnt_a;
            r_cnt_b <= w_cnt_b;
            r_r     <= w_r;
            r_idx   <= w_idx;
            r_op    <= w_op;
            r_c     <= w_c;
            r_neg   <= w_neg;
            r_disp  <= w_disp;
            r_neg_o <= w_neg_o;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign disp_code = r_disp;
    assign neg       = r_neg_o;
    assign busy      = r_busy;
    assign done      = r_done;
    assign phase     = r_state;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: key-by-key vector table plus
// a result scoreboard fed from an integer reference model.
module tb_calc_entry_ctrl;

    localparam int NDIG = 3;
    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_CLR = 4'hC;
    localparam logic [3:0] K_IGN = 4'hD;
    localparam logic [3:0] K_EQ  = 4'hE;
    localparam logic [3:0] K_BS  = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic        press;
    logic [3:0]  scan_code;
    logic [23:0] disp_code;
    logic        neg;
    logic        busy;
    logic        done;
    logic [1:0]  phase;

    int n_cmp = 0;
    int n_bad = 0;
    logic [24:0] sb_q[$];

    calc_entry_ctrl #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .press     (press),
        .scan_code (scan_code),
        .disp_code (disp_code),
        .neg       (neg),
        .busy      (busy),
        .done      (done),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, then BCD conversion
    function automatic logic [24:0] model(input int a, input int b,
                                          input bit sub);
        int r;
        logic n;
        logic [23:0] d;
        n = 1'b0;
        if (!sub) r = a + b;
        else if (a >= b) r = a - b;
        else begin
            r = b - a;
            n = 1'b1;
        end
        d = '0;
        for (int i = 0; i < 6; i++) begin
            d[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return {n, d};
    endfunction

    always @(negedge clk) begin
        logic [24:0] e;
        if (done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_done: got done=1 expected no result");
            end else begin
                e = sb_q.pop_front();
                chk("sb_disp", 32'(disp_code), 32'(e[23:0]));
                chk("sb_neg", 32'(neg), 32'(e[24]));
                chk("sb_phase", 32'(phase), 32'd3);
                chk("sb_busy", 32'(busy), 32'd0);
            end
        end
    end

    task automatic press_key(input logic [3:0] k);
        @(negedge clk);
        press = 1'b1;
        scan_code = k;
        @(negedge clk);
        press = 1'b0;
        scan_code = 4'h0;
    endtask

    task automatic press_num(input int v);
        int digs[$];
        do begin
            digs.push_front(v % 10);
            v = v / 10;
        end while (v > 0);
        foreach (digs[i]) press_key(4'(digs[i]));
    endtask

    // Returns on the first cycle after the equals edge
    task automatic run_calc(input int a, input int b,
                            input bit sub, input bit push);
        press_num(a);
        press_key(sub ? K_SUB : K_ADD);
        press_num(b);
        if (push) sb_q.push_back(model(a, b, sub));
        press_key(K_EQ);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no done expected done", nm);
        end
        @(negedge clk);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_phase"}, 32'(phase), 32'd0);
        chk({nm, "_disp"}, 32'(disp_code), 32'd0);
        chk({nm, "_neg"}, 32'(neg), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  key;
        logic [23:0] disp;
        logic [1:0]  ph;
    } vec_t;

    vec_t tbl[22];

    initial begin
        tbl[0]  = '{4'h1,  24'h000001, 2'd0};
        tbl[1]  = '{4'h2,  24'h000012, 2'd0};
        tbl[2]  = '{4'h3,  24'h000123, 2'd0};
        tbl[3]  = '{4'h4,  24'h000123, 2'd0};
        tbl[4]  = '{K_BS,  24'h000012, 2'd0};
        tbl[5]  = '{K_BS,  24'h000001, 2'd0};
        tbl[6]  = '{K_BS,  24'h000000, 2'd0};
        tbl[7]  = '{K_BS,  24'h000000, 2'd0};
        tbl[8]  = '{K_EQ,  24'h000000, 2'd0};
        tbl[9]  = '{K_IGN, 24'h000000, 2'd0};
        tbl[10] = '{K_ADD, 24'h000000, 2'd1};
        tbl[11] = '{K_EQ,  24'h000000, 2'd1};
        tbl[12] = '{K_SUB, 24'h000000, 2'd1};
        tbl[13] = '{4'h5,  24'h000005, 2'd1};
        tbl[14] = '{4'h9,  24'h000059, 2'd1};
        tbl[15] = '{K_BS,  24'h000005, 2'd1};
        tbl[16] = '{K_CLR, 24'h000000, 2'd0};
        tbl[17] = '{4'h7,  24'h000007, 2'd0};
        tbl[18] = '{4'h7,  24'h000077, 2'd0};
        tbl[19] = '{K_ADD, 24'h000000, 2'd1};
        tbl[20] = '{K_SUB, 24'h000000, 2'd1};
        tbl[21] = '{4'h9,  24'h000009, 2'd1};

        rst = 1'b1;
        press = 1'b0;
        scan_code = 4'h0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            press_key(tbl[i].key);
            chk($sformatf("tbl%0d_disp", i), 32'(disp_code),
                32'(tbl[i].disp));
            chk($sformatf("tbl%0d_phase", i), 32'(phase),
                32'(tbl[i].ph));
        end

        // 77 - 9 only gives 68 if the op was replaced by subtract
        sb_q.push_back(model(77, 9, 1'b1));
        press_key(K_EQ);
        wait_done("done_77_9");

        press_key(4'h9);
        chk("res_dig_phase", 32'(phase), 32'd0);
        chk("res_dig_disp", 32'(disp_code), 32'h000009);
        chk("res_dig_neg", 32'(neg), 32'd0);
        press_key(K_CLR);

        run_calc(123, 989, 1'b0, 1'b1);
        for (int i = 0; i < NDIG; i++) begin
            chk($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
            chk($sformatf("busyph_c%0d", i), 32'(phase), 32'd2);
            @(negedge clk);
        end
        chk("done_at_n1", 32'(done), 32'd1);
        @(negedge clk);
        chk("done_1cyc", 32'(done), 32'd0);
        press_key(K_CLR);

        run_calc(45, 678, 1'b1, 1'b1);
        wait_done("done_45_678");
        press_key(K_CLR);
        run_calc(0, 0, 1'b1, 1'b1);
        wait_done("done_0_0");
        press_key(K_CLR);
        run_calc(999, 999, 1'b0, 1'b1);
        wait_done("done_999_999");
        press_key(K_CLR);
        run_calc(100, 1, 1'b1, 1'b1);
        wait_done("done_100_1");
        press_key(K_CLR);

        run_calc(123, 989, 1'b0, 1'b1);
        press_key(4'h7);
        wait_done("done_key7");
        press_key(K_CLR);

        // Digit pressed on the final CALC edge must be dropped
        run_calc(12, 34, 1'b0, 1'b1);
        repeat (NDIG - 1) @(negedge clk);
        press = 1'b1;
        scan_code = 4'h5;
        @(negedge clk);
        press = 1'b0;
        scan_code = 4'h0;
        chk("coinc_phase", 32'(phase), 32'd3);
        chk("coinc_disp", 32'(disp_code), 32'h000046);
        press_key(K_CLR);

        run_calc(123, 989, 1'b0, 1'b0);
        press_key(K_CLR);
        chk_reset("abort");
        repeat (8) @(negedge clk);

        run_calc(55, 5, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("rst_mid");
        repeat (8) @(negedge clk);
        press_key(4'h3);
        chk("post_rst_disp", 32'(disp_code), 32'h000003);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
